// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite palette bank: flash FSM states,
// a 4-bit-per-channel RGB struct and the bank 0 power-on palette.
package sprite_palette_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } flash_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int DEFAULT_PAL_LEN = 16;

  // Entry 0 is white (transparent key), 2 is pure red, 3 is black.
  localparam rgb_t DEFAULT_PAL [DEFAULT_PAL_LEN] = '{
    12'hFFF, 12'h888, 12'hF00, 12'h000,
    12'h0F0, 12'h00F, 12'hFF0, 12'h0FF,
    12'hF0F, 12'h840, 12'hF80, 12'h444,
    12'hCCC, 12'h08F, 12'hF8C, 12'h4C4
  };

  function automatic logic [11:0] default_entry(input int idx);
    if (idx < DEFAULT_PAL_LEN) return DEFAULT_PAL[idx];
    return 12'h000;
  endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Timed flash effect: alternates ON/OFF half-periods of FLASH_HALF cycles
// for a programmable number of half-periods, then returns to IDLE.
module palette_flash_fsm
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_HALF = 6_250_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flash_start,
  input  logic [3:0]   flash_toggles,
  output logic         flash_on,
  output logic         flash_busy,
  output flash_state_t state_dbg
);

  localparam int CNT_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_HALF - 1);

  flash_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_rem;
  logic             r_flash_on;
  logic             r_flash_busy;

  // A start request wins over any half-period boundary in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_flash_on   <= 1'b0;
      r_flash_busy <= 1'b0;
    end else if (flash_start) begin
      r_cnt <= '0;
      if (flash_toggles != 4'd0) begin
        r_state      <= ON;
        r_rem        <= flash_toggles;
        r_flash_on   <= 1'b1;
        r_flash_busy <= 1'b1;
      end else begin
        r_state      <= IDLE;
        r_rem        <= '0;
        r_flash_on   <= 1'b0;
        r_flash_busy <= 1'b0;
      end
    end else begin
      case (r_state)
        ON, OFF: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_rem <= r_rem - 4'd1;
            if (r_rem == 4'd1) begin
              r_state      <= IDLE;
              r_flash_on   <= 1'b0;
              r_flash_busy <= 1'b0;
            end else if (r_state == ON) begin
              r_state    <= OFF;
              r_flash_on <= 1'b0;
            end else begin
              r_state    <= ON;
              r_flash_on <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign flash_on   = r_flash_on;
  assign flash_busy = r_flash_busy;
  assign state_dbg  = r_state;

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank palette lookup with a two-stage pipeline: stage 1 reads the
// register file, stage 2 applies transparency, flash and dim effects.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int CH_W       = 4,
  parameter int N_BANK     = 2,
  parameter int TRANSP_IDX = 0,
  parameter int FLASH_HALF = 6_250_000,
  localparam int BANK_W    = (N_BANK > 1) ? $clog2(N_BANK) : 1,
  localparam int N_ENT     = 1 << IDX_W,
  localparam int COL_W     = 3 * CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BANK_W-1:0] in_bank,
  input  logic [IDX_W-1:0]  in_index,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [COL_W-1:0]  wr_data,
  input  logic [1:0]        dim,
  input  logic              flash_start,
  input  logic [3:0]        flash_toggles,
  output logic              flash_busy,
  output flash_state_t      flash_state
);

  localparam logic [IDX_W-1:0] TRANSP_V = IDX_W'(TRANSP_IDX);

  function automatic logic [COL_W-1:0] def_color(input int idx);
    logic [11:0] e;
    e = default_entry(idx);
    return {CH_W'(e[11:8]), CH_W'(e[7:4]), CH_W'(e[3:0])};
  endfunction

  logic [COL_W-1:0] r_pal [N_BANK][N_ENT];

  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [COL_W-1:0] w_rd_raw;
  logic [COL_W-1:0] w_fx;
  logic             w_flash_on;

  logic             r_s1_valid;
  logic [COL_W-1:0] r_s1_raw;
  logic             r_s1_transp;

  logic             r_out_valid;
  logic [COL_W-1:0] r_out_col;
  logic             r_out_transp;

  // Bank-range guards collapse to constants when N_BANK fills the index space.
  if ((1 << BANK_W) == N_BANK) begin : g_full_bank
    assign w_rd_ok = 1'b1;
    assign w_wr_ok = 1'b1;
  end else begin : g_part_bank
    assign w_rd_ok = (int'(in_bank) < N_BANK);
    assign w_wr_ok = (int'(wr_bank) < N_BANK);
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  assign w_rd_raw = w_rd_ok ? r_pal[in_bank][in_index] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANK; b++) begin
        for (int i = 0; i < N_ENT; i++) begin
          r_pal[b][i] <= (b == 0) ? def_color(i) : '0;
        end
      end
    end else if (wr_en && w_wr_ok) begin
      r_pal[wr_bank][wr_addr] <= wr_data;
    end
  end

  palette_flash_fsm #(
    .FLASH_HALF (FLASH_HALF)
  ) u_flash (
    .clk           (clk),
    .rst_n         (rst_n),
    .flash_start   (flash_start),
    .flash_toggles (flash_toggles),
    .flash_on      (w_flash_on),
    .flash_busy    (flash_busy),
    .state_dbg     (flash_state)
  );

  always_comb begin
    w_fx = '0;
    if (r_s1_transp) begin
      w_fx = r_s1_raw;
    end else if (w_flash_on) begin
      w_fx = '1;
    end else begin
      w_fx = {r_s1_raw[3*CH_W-1 -: CH_W] >> dim,
              r_s1_raw[2*CH_W-1 -: CH_W] >> dim,
              r_s1_raw[CH_W-1   -: CH_W] >> dim};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_raw     <= '0;
      r_s1_transp  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_col    <= '0;
      r_out_transp <= 1'b0;
    end else begin
      r_s1_valid   <= in_valid;
      r_s1_raw     <= w_rd_raw;
      r_s1_transp  <= (in_index == TRANSP_V);
      r_out_valid  <= r_s1_valid;
      r_out_col    <= w_fx;
      r_out_transp <= r_s1_transp;
    end
  end

  assign out_valid   = r_out_valid;
  assign red         = r_out_col[3*CH_W-1 -: CH_W];
  assign green       = r_out_col[2*CH_W-1 -: CH_W];
  assign blue        = r_out_col[CH_W-1   -: CH_W];
  assign transparent = r_out_transp;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank with a short flash half-period.
module tb_sprite_palette_bank;
  import sprite_palette_pkg::*;

  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_bank = '0;
  logic [3:0]    in_index = '0;
  logic          out_valid;
  logic [3:0]    red, green, blue;
  logic          transparent;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_bank = '0;
  logic [3:0]    wr_addr = '0;
  logic [11:0]   wr_data = '0;
  logic [1:0]    dim = '0;
  logic          flash_start = 1'b0;
  logic [3:0]    flash_toggles = '0;
  logic          flash_busy;
  flash_state_t  flash_state;

  int checks = 0;
  int errors = 0;

  sprite_palette_bank #(
    .IDX_W(4), .CH_W(4), .N_BANK(2), .TRANSP_IDX(0), .FLASH_HALF(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bank(in_bank),
    .in_index(in_index), .out_valid(out_valid), .red(red), .green(green),
    .blue(blue), .transparent(transparent), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .dim(dim), .flash_start(flash_start),
    .flash_toggles(flash_toggles), .flash_busy(flash_busy), .flash_state(flash_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request, then idle until its result is registered.
  task automatic do_lookup(input logic [BW-1:0] b, input logic [3:0] idx, input logic [1:0] d);
    in_valid = 1'b1; in_bank = b; in_index = idx; dim = d;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    rst_n = 1'b0;
    tick(); tick();
    obs = {out_valid, transparent, red, green, blue, flash_busy};
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 15'h0);
    end
    checks++;
    if (flash_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", flash_state, IDLE);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lookup_default();
    logic [13:0] obs;
    logic [13:0] exp_v [6];
    logic [3:0]  idx_v [6];
    logic [1:0]  dim_v [6];
    logic [BW-1:0] bank_v [6];
    idx_v = '{4'd2, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5};
    dim_v = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0};
    bank_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_v = '{{2'b10, 12'hF00}, {2'b11, 12'hFFF}, {2'b10, 12'h100},
              {2'b10, 12'h000}, {2'b10, 12'h070}, {2'b10, 12'h000}};
    for (int i = 0; i < 6; i++) begin
      do_lookup(bank_v[i], idx_v[i], dim_v[i]);
      obs = {out_valid, transparent, red, green, blue};
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL lookup_default_%0d: got %h expected %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] obs;
    wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 4'd5; wr_data = 12'h8C4;
    in_valid = 1'b1; in_bank = 1'b1; in_index = 4'd5; dim = 2'd1;
    tick();
    wr_en = 1'b0;
    tick();
    obs = {out_valid, transparent, red, green, blue};
    checks++;
    if (obs !== {2'b10, 12'h000}) begin
      errors++; $display("FAIL collision_old_data: got %h expected %h", obs, {2'b10, 12'h000});
    end
    in_valid = 1'b0;
    tick();
    obs = {out_valid, transparent, red, green, blue};
    checks++;
    if (obs !== {2'b10, 12'h462}) begin
      errors++; $display("FAIL write_visible_next: got %h expected %h", obs, {2'b10, 12'h462});
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL valid_drop: got %b expected 0", out_valid);
    end
    do_lookup(1'b1, 4'd5, 2'd2);
    obs = {out_valid, transparent, red, green, blue};
    checks++;
    if (obs !== {2'b10, 12'h231}) begin
      errors++; $display("FAIL dim2: got %h expected %h", obs, {2'b10, 12'h231});
    end
    do_lookup(1'b1, 4'd5, 2'd3);
    obs = {out_valid, transparent, red, green, blue};
    checks++;
    if (obs !== {2'b10, 12'h110}) begin
      errors++; $display("FAIL dim3: got %h expected %h", obs, {2'b10, 12'h110});
    end
  endtask

  task automatic test_flash_transparent();
    logic [13:0] obs;
    flash_start = 1'b1; flash_toggles = 4'd3;
    in_valid = 1'b1; in_bank = 1'b0; in_index = 4'd0; dim = 2'd2;
    tick();
    flash_start = 1'b0; in_index = 4'd2;
    tick();
    obs = {out_valid, transparent, red, green, blue};
    checks++;
    if (obs !== {2'b11, 12'hFFF}) begin
      errors++; $display("FAIL transp_in_flash: got %h expected %h", obs, {2'b11, 12'hFFF});
    end
    in_valid = 1'b0;
    tick();
    obs = {out_valid, transparent, red, green, blue};
    checks++;
    if (obs !== {2'b10, 12'hFFF}) begin
      errors++; $display("FAIL flash_white: got %h expected %h", obs, {2'b10, 12'hFFF});
    end
    flash_start = 1'b1; flash_toggles = 4'd0;
    tick();
    flash_start = 1'b0;
    checks++;
    if (flash_busy !== 1'b0 || flash_state !== IDLE) begin
      errors++; $display("FAIL flash_stop: got busy=%b state=%0d expected busy=0 state=0", flash_busy, flash_state);
    end
    dim = 2'd0;
  endtask

  task automatic test_flash_sequence();
    logic [11:0]  obs;
    logic [11:0]  exp_col;
    flash_state_t exp_st;
    logic         prev_on;
    int           busy_cnt;
    in_valid = 1'b1; in_bank = 1'b0; in_index = 4'd3; dim = 2'd0;
    tick(); tick();
    prev_on = 1'b0;
    busy_cnt = 0;
    flash_start = 1'b1; flash_toggles = 4'd3;
    for (int j = 0; j < 14; j++) begin
      tick();
      flash_start = 1'b0;
      exp_st = (j < 4) ? ON : (j < 8) ? OFF : (j < 12) ? ON : IDLE;
      exp_col = prev_on ? 12'hFFF : 12'h000;
      if (flash_busy) busy_cnt++;
      checks++;
      if (flash_state !== exp_st) begin
        errors++; $display("FAIL seq_state_%0d: got %0d expected %0d", j, flash_state, exp_st);
      end
      obs = {red, green, blue};
      checks++;
      if (obs !== exp_col || out_valid !== 1'b1) begin
        errors++; $display("FAIL seq_color_%0d: got %h valid=%b expected %h valid=1", j, obs, out_valid, exp_col);
      end
      prev_on = (exp_st == ON);
    end
    checks++;
    if (busy_cnt != 12) begin
      errors++; $display("FAIL busy_cycles: got %0d expected 12", busy_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flash_restart();
    flash_start = 1'b1; flash_toggles = 4'd3;
    tick();
    flash_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (flash_state !== OFF) begin
      errors++; $display("FAIL restart_pre_off: got %0d expected %0d", flash_state, OFF);
    end
    flash_start = 1'b1;
    tick();
    flash_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (flash_state !== ON) begin
        errors++; $display("FAIL restart_on_%0d: got %0d expected %0d", k, flash_state, ON);
      end
      tick();
    end
    checks++;
    if (flash_state !== OFF) begin
      errors++; $display("FAIL restart_full_count: got %0d expected %0d", flash_state, OFF);
    end
    // Start on the terminal edge of a single half-period must re-arm, not idle.
    flash_start = 1'b1; flash_toggles = 4'd1;
    tick();
    flash_start = 1'b0;
    tick(); tick(); tick();
    flash_start = 1'b1; flash_toggles = 4'd2;
    tick();
    flash_start = 1'b0;
    checks++;
    if (flash_state !== ON) begin
      errors++; $display("FAIL start_priority: got %0d expected %0d", flash_state, ON);
    end
    flash_start = 1'b1; flash_toggles = 4'd0;
    tick();
    flash_start = 1'b0;
    checks++;
    if (flash_state !== IDLE || flash_busy !== 1'b0) begin
      errors++; $display("FAIL zero_toggle_idle: got state=%0d busy=%b expected 0 0", flash_state, flash_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] obs;
    logic [13:0] lk;
    in_valid = 1'b1; in_bank = 1'b0; in_index = 4'd2; dim = 2'd0;
    flash_start = 1'b1; flash_toggles = 4'd5;
    tick();
    flash_start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    obs = {out_valid, transparent, red, green, blue, flash_busy};
    checks++;
    if (obs !== 15'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected %h", obs, 15'h0);
    end
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    do_lookup(1'b1, 4'd5, 2'd0);
    lk = {out_valid, transparent, red, green, blue};
    checks++;
    if (lk !== {2'b10, 12'h000}) begin
      errors++; $display("FAIL bank1_cleared: got %h expected %h", lk, {2'b10, 12'h000});
    end
    do_lookup(1'b0, 4'd2, 2'd0);
    lk = {out_valid, transparent, red, green, blue};
    checks++;
    if (lk !== {2'b10, 12'hF00}) begin
      errors++; $display("FAIL bank0_restored: got %h expected %h", lk, {2'b10, 12'hF00});
    end
  endtask

  initial begin
    test_reset();
    test_lookup_default();
    test_back_to_back();
    test_flash_transparent();
    test_flash_sequence();
    test_flash_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
